// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of a single I2cMaster among several clients.
// Latches the winner's transaction onto the master, pulses start, and returns read data plus status.
module i2c_bus_arbiter #(
    parameter int NrOfRequesters = 2,
    parameter int MaxBytesToSend = 16,
    parameter int MaxBytesToRead = 16,
    parameter int BusyTimeout    = 2000
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic [NrOfRequesters-1:0]                            request,
    input  logic [NrOfRequesters-1:0][6:0]                       address,
    input  logic [NrOfRequesters-1:0][$clog2(MaxBytesToSend):0]  nrOfBytesToSend,
    input  logic [NrOfRequesters-1:0][MaxBytesToSend-1:0][7:0]   bytesToSend,
    input  logic [NrOfRequesters-1:0][$clog2(MaxBytesToRead):0]  nrOfBytesToRead,
    output logic [NrOfRequesters-1:0]                            grant,
    output logic [NrOfRequesters-1:0]                            done,
    output logic [2:0]                                           error,
    output logic [MaxBytesToRead-1:0][7:0]                       bytesRead,
    output logic                                                 masterStart,
    output logic [6:0]                                           masterAddress,
    output logic [$clog2(MaxBytesToSend):0]                      masterNrOfBytesToSend,
    output logic [MaxBytesToSend-1:0][7:0]                       masterBytesToSend,
    output logic [$clog2(MaxBytesToRead):0]                      masterNrOfBytesToRead,
    input  logic [MaxBytesToRead-1:0][7:0]                       masterBytesToRead,
    input  logic                                                 masterReady,
    input  logic                                                 masterStretchTimeout,
    input  logic                                                 masterNoAck
);

    localparam int IdxW  = $clog2(NrOfRequesters);
    localparam int CntW  = $clog2(BusyTimeout + 1);
    localparam int SendW = $clog2(MaxBytesToSend) + 1;
    localparam int ReadW = $clog2(MaxBytesToRead) + 1;

    typedef enum logic [2:0] {
        Idle,
        Issue,
        WaitBusy,
        WaitDone,
        Report
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [NrOfRequesters-1:0]       r_grant;
    logic [IdxW-1:0]                 r_pointer;
    logic [IdxW-1:0]                 r_owner;
    logic [IdxW-1:0]                 w_pick;
    logic                            w_any;
    logic                            w_busyExpired;
    logic [CntW-1:0]                 r_busyCnt;
    logic [2:0]                      r_error;
    logic [MaxBytesToRead-1:0][7:0]  r_bytesRead;
    logic [6:0]                      r_mAddress;
    logic [SendW-1:0]                r_mNrSend;
    logic [MaxBytesToSend-1:0][7:0]  r_mBytesSend;
    logic [ReadW-1:0]                r_mNrRead;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int unsigned w_idx;
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int unsigned i = 0; i < NrOfRequesters; i++) begin
            w_idx = (32'(r_pointer) + i) % NrOfRequesters;
            if (!w_any && request[IdxW'(w_idx)]) begin
                w_any  = 1'b1;
                w_pick = IdxW'(w_idx);
            end
        end
    end

    assign w_busyExpired = masterReady && (r_busyCnt == CntW'(BusyTimeout - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= Idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            Idle:     if (w_any) w_next = Issue;
            Issue:    w_next = WaitBusy;
            WaitBusy: begin
                if (!masterReady) begin
                    w_next = WaitDone;
                end else if (w_busyExpired) begin
                    w_next = Report;
                end
            end
            WaitDone: if (masterReady) w_next = Report;
            Report:   w_next = Idle;
            default:  w_next = Idle;
        endcase
    end

    always_comb begin
        masterStart = (r_state == Issue);
        done        = '0;
        if (r_state == Report) begin
            done = r_grant;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_grant      <= '0;
            r_pointer    <= '0;
            r_owner      <= '0;
            r_busyCnt    <= '0;
            r_error      <= '0;
            r_bytesRead  <= '0;
            r_mAddress   <= '0;
            r_mNrSend    <= '0;
            r_mBytesSend <= '0;
            r_mNrRead    <= '0;
        end else begin
            case (r_state)
                Idle: begin
                    if (w_any) begin
                        r_grant      <= NrOfRequesters'(1) << w_pick;
                        r_owner      <= w_pick;
                        r_mAddress   <= address[w_pick];
                        r_mNrSend    <= nrOfBytesToSend[w_pick];
                        r_mBytesSend <= bytesToSend[w_pick];
                        r_mNrRead    <= nrOfBytesToRead[w_pick];
                    end
                end
                Issue: begin
                    r_busyCnt <= '0;
                end
                WaitBusy: begin
                    if (masterReady) begin
                        r_busyCnt <= r_busyCnt + 1'b1;
                        if (w_busyExpired) begin
                            r_error <= 3'b100;
                        end
                    end
                end
                WaitDone: begin
                    if (masterReady) begin
                        r_bytesRead <= masterBytesToRead;
                        r_error     <= {1'b0, masterStretchTimeout, masterNoAck};
                    end
                end
                Report: begin
                    r_grant   <= '0;
                    r_pointer <= (r_owner == IdxW'(NrOfRequesters - 1)) ? '0 : r_owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grant                 = r_grant;
    assign error                 = r_error;
    assign bytesRead             = r_bytesRead;
    assign masterAddress         = r_mAddress;
    assign masterNrOfBytesToSend = r_mNrSend;
    assign masterBytesToSend     = r_mBytesSend;
    assign masterNrOfBytesToRead = r_mNrRead;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a simple I2cMaster ready/data model.
module tb_i2c_bus_arbiter;

    localparam int N  = 2;
    localparam int MS = 16;
    localparam int MR = 16;
    localparam int BT = 40;

    localparam int M_NORMAL  = 0;
    localparam int M_NOACK   = 1;
    localparam int M_STRETCH = 2;
    localparam int M_NEVER   = 3;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [N-1:0]              request;
    logic [N-1:0][6:0]         address;
    logic [N-1:0][4:0]         nrOfBytesToSend;
    logic [N-1:0][MS-1:0][7:0] bytesToSend;
    logic [N-1:0][4:0]         nrOfBytesToRead;
    logic [N-1:0]              grant;
    logic [N-1:0]              done;
    logic [2:0]                error;
    logic [MR-1:0][7:0]        bytesRead;
    logic                      masterStart;
    logic [6:0]                masterAddress;
    logic [4:0]                masterNrOfBytesToSend;
    logic [MS-1:0][7:0]        masterBytesToSend;
    logic [4:0]                masterNrOfBytesToRead;
    logic [MR-1:0][7:0]        masterBytesToRead;
    logic                      masterReady;
    logic                      masterStretchTimeout;
    logic                      masterNoAck;

    i2c_bus_arbiter #(
        .NrOfRequesters(N),
        .MaxBytesToSend(MS),
        .MaxBytesToRead(MR),
        .BusyTimeout(BT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .request(request),
        .address(address),
        .nrOfBytesToSend(nrOfBytesToSend),
        .bytesToSend(bytesToSend),
        .nrOfBytesToRead(nrOfBytesToRead),
        .grant(grant),
        .done(done),
        .error(error),
        .bytesRead(bytesRead),
        .masterStart(masterStart),
        .masterAddress(masterAddress),
        .masterNrOfBytesToSend(masterNrOfBytesToSend),
        .masterBytesToSend(masterBytesToSend),
        .masterNrOfBytesToRead(masterNrOfBytesToRead),
        .masterBytesToRead(masterBytesToRead),
        .masterReady(masterReady),
        .masterStretchTimeout(masterStretchTimeout),
        .masterNoAck(masterNoAck)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         m_mode = M_NORMAL;
    logic [7:0] m_base = 8'h00;
    int         m_nread = 0;

    typedef struct {
        int         client;
        logic [6:0] addr;
        logic [4:0] nsend;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [4:0] nread;
        int         mode;
        logic [7:0] base;
        logic [2:0] experr;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [127:0] make_read(input logic [7:0] base, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Master model: ready falls 3 clocks after start, returns 50 clocks later with data/status.
    initial begin
        masterReady          = 1'b1;
        masterNoAck          = 1'b0;
        masterStretchTimeout = 1'b0;
        masterBytesToRead    = '0;
        forever begin
            @(posedge clock); #1;
            if (masterStart) begin
                repeat (3) @(posedge clock);
                #1;
                if (m_mode != M_NEVER) begin
                    masterReady = 1'b0;
                    for (int k = 0; k < 50 && reset; k++) @(posedge clock);
                    #1;
                    for (int i = 0; i < MR; i++)
                        masterBytesToRead[i] = (i < m_nread) ? m_base + 8'(i) : 8'h00;
                    masterNoAck          = (m_mode == M_NOACK);
                    masterStretchTimeout = (m_mode == M_STRETCH);
                    masterReady          = 1'b1;
                end
            end
        end
    end

    task automatic wait_grant(input int owner, input logic [6:0] exp_addr, input string tag,
                              output int cycles);
        cycles = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            cycles++;
            if (grant != '0) break;
        end
        check({tag, "_grant"}, 128'(grant), 128'(N'(1) << owner));
        check({tag, "_start"}, 128'(masterStart), 128'(1'b1));
        check({tag, "_addr"}, 128'(masterAddress), 128'(exp_addr));
    endtask

    task automatic wait_done(input int owner, input logic [6:0] exp_addr, input logic [2:0] experr,
                             input logic [127:0] expread, input string tag);
        int   extra_starts;
        logic got;
        logic addr_bad;
        extra_starts = 0;
        got          = 1'b0;
        addr_bad     = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clock); #1;
            if (masterStart) extra_starts++;
            if (masterAddress !== exp_addr) addr_bad = 1'b1;
            if (done != '0) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 128'(got), 128'(1'b1));
        check({tag, "_done"}, 128'(done), 128'(N'(1) << owner));
        check({tag, "_error"}, 128'(error), 128'(experr));
        check({tag, "_bytesRead"}, bytesRead, expread);
        check({tag, "_extra_starts"}, 128'(extra_starts), 128'(0));
        check({tag, "_addr_held"}, 128'(addr_bad), 128'(1'b0));
        @(posedge clock); #1;
        check({tag, "_done_cleared"}, 128'(done), 128'(0));
        check({tag, "_grant_cleared"}, 128'(grant), 128'(0));
    endtask

    initial begin
        int           cyc;
        logic [127:0] cur_read;
        logic [127:0] exp_send;

        vecs[0] = '{0, 7'h68, 5'd1,  8'h00, 8'h00, 5'd7,  M_NORMAL,  8'h01, 3'b000};
        vecs[1] = '{1, 7'h50, 5'd2,  8'hAA, 8'h55, 5'd3,  M_NOACK,   8'h10, 3'b001};
        vecs[2] = '{0, 7'h3C, 5'd0,  8'h00, 8'h00, 5'd4,  M_STRETCH, 8'h20, 3'b010};
        vecs[3] = '{1, 7'h22, 5'd1,  8'h5A, 8'h00, 5'd2,  M_NEVER,   8'h30, 3'b100};
        vecs[4] = '{0, 7'h11, 5'd16, 8'hC3, 8'h3C, 5'd16, M_NORMAL,  8'h80, 3'b000};

        reset           = 1'b0;
        request         = '0;
        address         = '0;
        nrOfBytesToSend = '0;
        bytesToSend     = '0;
        nrOfBytesToRead = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_grant", 128'(grant), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_error", 128'(error), 128'(0));
        check("rst_bytesRead", bytesRead, 128'(0));
        check("rst_start", 128'(masterStart), 128'(0));
        check("rst_maddr", 128'(masterAddress), 128'(0));
        reset = 1'b1;

        // Both clients from reset, held: service order 0,1,0,1.
        address[0]         = 7'h68;
        address[1]         = 7'h50;
        nrOfBytesToRead[0] = 5'd2;
        nrOfBytesToRead[1] = 5'd2;
        m_mode  = M_NORMAL;
        m_base  = 8'h40;
        m_nread = 2;
        request = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wait_grant(r % 2, (r % 2 == 0) ? 7'h68 : 7'h50, $sformatf("rr%0d", r), cyc);
            wait_done(r % 2, (r % 2 == 0) ? 7'h68 : 7'h50, 3'b000, make_read(8'h40, 2),
                      $sformatf("rr%0d", r));
        end
        request  = '0;
        cur_read = make_read(8'h40, 2);

        foreach (vecs[v]) begin
            int c;
            c = vecs[v].client;
            address[c]         = vecs[v].addr;
            nrOfBytesToSend[c] = vecs[v].nsend;
            bytesToSend[c]     = '0;
            bytesToSend[c][0]  = vecs[v].p0;
            bytesToSend[c][1]  = vecs[v].p1;
            nrOfBytesToRead[c] = vecs[v].nread;
            m_mode  = vecs[v].mode;
            m_base  = vecs[v].base;
            m_nread = int'(vecs[v].nread);
            exp_send = {112'b0, vecs[v].p1, vecs[v].p0};
            if (vecs[v].mode != M_NEVER) cur_read = make_read(vecs[v].base, int'(vecs[v].nread));
            request[c] = 1'b1;
            wait_grant(c, vecs[v].addr, $sformatf("v%0d", v), cyc);
            check($sformatf("v%0d_latency", v), 128'(cyc), 128'(1));
            check($sformatf("v%0d_nsend", v), 128'(masterNrOfBytesToSend), 128'(vecs[v].nsend));
            check($sformatf("v%0d_payload", v), masterBytesToSend, exp_send);
            check($sformatf("v%0d_nread", v), 128'(masterNrOfBytesToRead), 128'(vecs[v].nread));
            wait_done(c, vecs[v].addr, vecs[v].experr, cur_read, $sformatf("v%0d", v));
            request[c] = 1'b0;
        end

        // Address changed and request dropped while granted: latched copy stays, done still pulses.
        address[0]         = 7'h68;
        nrOfBytesToRead[0] = 5'd3;
        m_mode  = M_NORMAL;
        m_base  = 8'hA0;
        m_nread = 3;
        request[0] = 1'b1;
        wait_grant(0, 7'h68, "chg", cyc);
        address[0] = 7'h50;
        request[0] = 1'b0;
        wait_done(0, 7'h68, 3'b000, make_read(8'hA0, 3), "chg");

        // Reset during WaitDone with pointer at 1: no done, outputs cleared, pointer back to 0.
        address[1]         = 7'h33;
        nrOfBytesToRead[1] = 5'd1;
        request[1] = 1'b1;
        wait_grant(1, 7'h33, "rstmid", cyc);
        for (int c = 0; c < 10 && masterReady; c++) begin
            @(posedge clock); #1;
        end
        check("rstmid_ready_low", 128'(masterReady), 128'(1'b0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("rstmid_grant", 128'(grant), 128'(0));
        check("rstmid_start", 128'(masterStart), 128'(0));
        check("rstmid_done", 128'(done), 128'(0));
        check("rstmid_maddr", 128'(masterAddress), 128'(0));
        check("rstmid_bytesRead", bytesRead, 128'(0));
        @(posedge clock); #1;
        check("rstmid_done2", 128'(done), 128'(0));
        reset   = 1'b1;
        m_base  = 8'h55;
        m_nread = 3;
        request = 2'b11;
        wait_grant(0, 7'h50, "after_rst", cyc);
        wait_done(0, 7'h50, 3'b000, make_read(8'h55, 3), "after_rst");
        request = '0;
        repeat (3) @(posedge clock);
        #1;
        check("idle_grant", 128'(grant), 128'(0));
        check("idle_start", 128'(masterStart), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
